serial_sub: RTL and testbench

Bit-serial unsigned subtractor: computes d = a - b over WIDTH clock cycles, LSB first. It uses one full-subtractor cell per cycle plus a registered borrow. It sits directly downstream of the one-bit full-subtractor cell. It feeds the cell one bit pair and the stored borrow each cycle, and consumes the cell's difference and borrow outputs. A start/busy/done handshake frames each operation.

---
 rtl/serial_sub.sv | 95 +++++++++
 tb/tb_serial_sub.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor, LSB first, one full-subtractor cell plus a registered borrow.
// Start-to-done latency is WIDTH+1 edges; start is accepted in IDLE or DONE and ignored while busy.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] DONE_ST = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             bit_d;
  logic             bit_b;

  full_sub_cell u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (br),
    .diff (bit_d),
    .bout (bit_b)
  );

  assign busy = (state == RUN);
  assign done = (state == DONE_ST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      bo     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {bit_d, res_sh[WIDTH-1:1]};
          br     <= bit_b;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            d     <= {bit_d, res_sh[WIDTH-1:1]};
            bo    <= bit_b;
            state <= DONE_ST;
          end
        end
        default: begin
          // IDLE and DONE accept alike, so held start gives back-to-back ops
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// One-bit full subtractor: diff = x - y - bin, bout = borrow out.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = x ^ y ^ bin;
  assign bout = (~x & (y | bin)) | (y & bin);
endmodule

// File: tb/tb_serial_sub.sv
// Scoreboarded bench for serial_sub at WIDTH=8 and WIDTH=16 sharing clock and reset.
module tb_serial_sub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, d8;
  logic        busy8, done8, bo8;
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, d16;
  logic        busy16, done16, bo16;

  int compares = 0;
  int fails = 0;
  logic [8:0]  q8[$];
  logic [16:0] q16[$];

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .d(d8), .bo(bo8)
  );

  serial_sub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .d(d16), .bo(bo16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors, sampled on the falling edge
  always @(negedge clk) begin
    logic [8:0]  e8;
    logic [16:0] e16;
    check("busy_done_overlap8", {31'd0, busy8 & done8}, 32'd0);
    check("busy_done_overlap16", {31'd0, busy16 & done16}, 32'd0);
    if (done8) begin
      check("done8_expected", {31'd0, q8.size() != 0}, 32'd1);
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        check("result8", {23'd0, bo8, d8}, {23'd0, e8});
      end
    end
    if (done16) begin
      check("done16_expected", {31'd0, q16.size() != 0}, 32'd1);
      if (q16.size() != 0) begin
        e16 = q16.pop_front();
        check("result16", {15'd0, bo16, d16}, {15'd0, e16});
      end
    end
  end

  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] df;
    df = x - y;
    return {x < y, df};
  endfunction

  function automatic logic [16:0] model16(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] df;
    df = x - y;
    return {x < y, df};
  endfunction

  task automatic op8(input logic [7:0] x, input logic [7:0] y);
    int g = 0;
    while (busy8 && g < 40) begin tick(); g++; end
    check("op8_idle_wait", {31'd0, busy8}, 32'd0);
    start8 = 1'b1; a8 = x; b8 = y;
    q8.push_back(model8(x, y));
    tick();
    start8 = 1'b0;
  endtask

  task automatic op16(input logic [15:0] x, input logic [15:0] y);
    int g = 0;
    while (busy16 && g < 60) begin tick(); g++; end
    check("op16_idle_wait", {31'd0, busy16}, 32'd0);
    start16 = 1'b1; a16 = x; b16 = y;
    q16.push_back(model16(x, y));
    tick();
    start16 = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((q8.size() != 0 || q16.size() != 0) && g < 100) begin tick(); g++; end
    check("drain8", q8.size(), 0);
    check("drain16", q16.size(), 0);
  endtask

  initial begin
    int cyc;
    int dcount;
    logic [7:0] x, y;

    #2;
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    check("rst_done8", {31'd0, done8}, 32'd0);
    check("rst_d8", {24'd0, d8}, 32'd0);
    check("rst_bo8", {31'd0, bo8}, 32'd0);
    check("rst_d16", {16'd0, d16}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Latency framing: busy for 8 samples after acceptance, then one done
    op8(8'h05, 8'h03);
    for (int i = 0; i < 8; i++) begin
      check("lat_busy", {31'd0, busy8}, 32'd1);
      check("lat_nodone", {31'd0, done8}, 32'd0);
      tick();
    end
    check("lat_busy_end", {31'd0, busy8}, 32'd0);
    check("lat_done", {31'd0, done8}, 32'd1);
    tick();
    check("lat_done_pulse", {31'd0, done8}, 32'd0);
    repeat (3) tick();
    check("hold_d", {24'd0, d8}, 32'h02);
    drain();

    op8(8'h03, 8'h05);
    drain();
    op8(8'h00, 8'hFF);
    drain();

    // Start pulses and operand changes mid-run must be ignored
    op8(8'h80, 8'h01);
    tick(); tick();
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
    tick(); tick();
    start8 = 1'b0;
    check("hold_d_during_run", {24'd0, d8}, 32'h01);
    check("hold_bo_during_run", {31'd0, bo8}, 32'd1);
    drain();

    op8(8'hFF, 8'hFF);
    drain();

    // Held start: one completion every 9 cycles, operands taken at each accepting edge
    start8 = 1'b1;
    x = 8'($urandom); y = 8'($urandom);
    a8 = x; b8 = y; q8.push_back(model8(x, y));
    for (int k = 0; k < 6; k++) begin
      cyc = 0;
      do begin tick(); cyc++; end while (!done8 && cyc < 20);
      check("held_period", cyc, 9);
      if (k < 5) begin
        x = 8'($urandom); y = 8'($urandom);
        a8 = x; b8 = y; q8.push_back(model8(x, y));
      end else begin
        start8 = 1'b0;
      end
    end
    drain();

    // Asynchronous reset partway through a run
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy8}, 32'd0);
    check("arst_done", {31'd0, done8}, 32'd0);
    check("arst_d", {24'd0, d8}, 32'd0);
    check("arst_bo", {31'd0, bo8}, 32'd0);
    tick();
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) dcount++;
      tick();
    end
    check("arst_no_done", dcount, 0);
    op8(8'h10, 8'h01);
    drain();

    for (int i = 0; i < 1000; i++) op8(8'($urandom), 8'($urandom));
    drain();
    for (int i = 0; i < 1000; i++) op16(16'($urandom), 16'($urandom));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
